// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32 core: word RAM plus an I/O page
// holding a GPIO output register and a 32-bit compare-match timer with interrupt.
module dmem_responder #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     MEM_WORDS = 256,
  parameter logic [XLEN-1:0] IO_BASE   = 32'h0001_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] gpio_o,
  output logic            irq_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [5:0] {
    REG_GPIO = 6'h00,
    REG_CNT  = 6'h01,
    REG_CMP  = 6'h02,
    REG_STAT = 6'h03,
    REG_CTRL = 6'h04
  } io_reg_e;

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [XLEN-1:0] gpio_q;
  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cmp_q;
  logic [1:0]      ctrl_q;
  logic            flag_q;

  logic          ram_sel;
  logic          io_sel;
  logic [AW-1:0] ram_idx;
  logic [5:0]    io_off;
  logic          io_we;
  logic          unused_bits;

  // Upper RAM index bits in [15:AW+2] are deliberately ignored, so the RAM aliases.
  assign ram_sel     = (addr_i[XLEN-1:16] == '0);
  assign io_sel      = (addr_i[XLEN-1:16] == IO_BASE[XLEN-1:16]);
  assign ram_idx     = addr_i[AW+1:2];
  assign io_off      = addr_i[7:2];
  assign io_we       = we_i && io_sel;
  assign unused_bits = ^addr_i;

  // RAM has no reset value; the reset arm only blocks writes while reset is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
    end else if (we_i && ram_sel) begin
      mem[ram_idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_q <= '0;
      cnt_q  <= '0;
      cmp_q  <= '1;
      ctrl_q <= '0;
      flag_q <= 1'b0;
    end else begin
      if (io_we && io_off == REG_GPIO) gpio_q <= wdata_i;
      if (io_we && io_off == REG_CMP)  cmp_q  <= wdata_i;
      if (io_we && io_off == REG_CTRL) ctrl_q <= wdata_i[1:0];

      if (io_we && io_off == REG_CNT)
        cnt_q <= wdata_i;
      else if (ctrl_q[0])
        cnt_q <= cnt_q + 1'b1;

      // Match on the pre-increment count; a same-cycle clear loses to a new match.
      if (ctrl_q[0] && cnt_q == cmp_q)
        flag_q <= 1'b1;
      else if (io_we && io_off == REG_STAT && wdata_i[0])
        flag_q <= 1'b0;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (ram_sel) begin
      rdata_o = mem[ram_idx];
    end else if (io_sel) begin
      case (io_off)
        REG_GPIO: rdata_o = gpio_q;
        REG_CNT:  rdata_o = cnt_q;
        REG_CMP:  rdata_o = cmp_q;
        REG_STAT: rdata_o = {{(XLEN-1){1'b0}}, flag_q};
        REG_CTRL: rdata_o = {{(XLEN-2){1'b0}}, ctrl_q};
        default:  rdata_o = '0;
      endcase
    end
  end

  assign gpio_o = gpio_q;
  assign irq_o  = flag_q & ctrl_q[1];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_responder;

  localparam logic [31:0] IO   = 32'h0001_0000;
  localparam logic [31:0] GPIO = IO + 32'h00;
  localparam logic [31:0] CNT  = IO + 32'h04;
  localparam logic [31:0] CMP  = IO + 32'h08;
  localparam logic [31:0] STAT = IO + 32'h0C;
  localparam logic [31:0] CTRL = IO + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [31:0] gpio;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 rdata, 1 gpio, 2 irq
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(
    .XLEN     (32),
    .MEM_WORDS(256),
    .IO_BASE  (32'h0001_0000)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .gpio_o (gpio),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = rdata;
        1:       act = gpio;
        default: act = {31'd0, irq};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  function automatic void expect_out(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = 1'b1; addr = a; wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    we = 1'b0; addr = a; wdata = $urandom;
    expect_out(0, exp, name);
  endtask

  task automatic idle(input logic [31:0] a);
    @(posedge clk); #1;
    we = 1'b0; addr = a; wdata = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state, read combinationally while reset is held
    repeat (2) @(posedge clk);
    #1;
    addr = CMP;
    expect_out(0, 32'hFFFF_FFFF, "rst_cmp");
    expect_out(1, 32'h0, "rst_gpio");
    expect_out(2, 32'h0, "rst_irq");
    @(posedge clk); #1;
    rst = 1'b0;
    addr = CTRL;
    expect_out(0, 32'h0, "rst_ctrl");
    rd(CNT,  32'h0, "rst_cnt");
    rd(STAT, 32'h0, "rst_stat");

    // RAM, aliasing, out-of-range
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0002_0000, 32'h0, "unmapped");
    wr(32'h0000_03FC, 32'h1234_5678);
    rd(32'h0000_03FC, 32'h1234_5678, "ram_top");
    rd(32'h0000_FFFC, 32'h1234_5678, "ram_top_alias");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_keep");

    // GPIO and async reset (write during reset dropped)
    wr(GPIO, 32'h0000_00A5);
    rd(GPIO, 32'h0000_00A5, "gpio_rd");
    expect_out(1, 32'h0000_00A5, "gpio_out");
    @(posedge clk); #1;
    we = 1'b1; addr = GPIO; wdata = 32'h0000_005A;
    #1 rst = 1'b1;
    expect_out(1, 32'h0, "gpio_async_rst");
    @(posedge clk); #1;
    we = 1'b0;
    rst = 1'b0;
    expect_out(0, 32'h0, "gpio_wr_in_rst");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_after_rst");

    // timer compare and irq
    wr(CMP, 32'd5);
    wr(CNT, 32'd0);
    wr(CTRL, 32'd3);
    rd(CNT, 32'd0, "t3_cnt0");
    rd(STAT, 32'd0, "t3_stat0");
    idle(CNT); idle(CNT); idle(CNT);
    rd(CNT, 32'd5, "t3_cnt5");
    expect_out(2, 32'd0, "t3_irq_pre");
    rd(STAT, 32'd1, "t3_flag");
    expect_out(2, 32'd1, "t3_irq");
    wr(STAT, 32'd1);
    rd(CNT, 32'd8, "t3_cnt_run");
    expect_out(2, 32'd0, "t3_irq_clr");

    // wrap and compare at zero, irq masked
    wr(CTRL, 32'd0);
    wr(STAT, 32'd1);
    wr(CNT, 32'hFFFF_FFFE);
    wr(CMP, 32'd0);
    wr(CTRL, 32'd1);
    rd(CNT, 32'hFFFF_FFFE, "t4_cnt_fe");
    rd(CNT, 32'hFFFF_FFFF, "t4_cnt_ff");
    rd(STAT, 32'd0, "t4_no_wrap_flag");
    rd(STAT, 32'd1, "t4_flag");
    expect_out(2, 32'd0, "t4_irq_masked");
    rd(CNT, 32'd2, "t4_cnt2");

    // same-cycle events
    wr(CNT, 32'd100);
    rd(CNT, 32'd100, "t5_load_wins");
    rd(CNT, 32'd101, "t5_inc");
    wr(STAT, 32'd1);
    wr(CMP, 32'd106);
    idle(CNT);
    rd(STAT, 32'd0, "t5_stat_clr");
    wr(STAT, 32'd1);
    rd(STAT, 32'd1, "t5_set_wins");

    // CTRL masking, undefined offset, we_i=0
    wr(CTRL, 32'hFFFF_FFFF);
    rd(CTRL, 32'd3, "t6_ctrl_mask");
    expect_out(2, 32'd1, "t6_irq");
    wr(IO + 32'h20, 32'h1234_5678);
    rd(IO + 32'h20, 32'd0, "t6_undef");
    rd(GPIO, 32'd0, "t6_gpio_keep");
    rd(CMP, 32'd106, "t6_cmp_keep");
    wr(CTRL, 32'd0);
    wr(CNT, 32'h55);
    for (int unsigned i = 0; i < 4; i++) begin
      idle(CNT);
      idle(STAT);
      idle(GPIO);
      idle(32'h0000_0010);
    end
    rd(CNT, 32'h55, "t6_cnt_hold");
    rd(STAT, 32'd1, "t6_flag_hold");
    rd(GPIO, 32'd0, "t6_gpio_hold");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "t6_ram_hold");
    rd(CTRL, 32'd0, "t6_ctrl_hold");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
